// File: rtl/dog_pkg.sv
// Shared types and defaults for the Difference-of-Gaussians stage.
package dog_pkg;

    typedef logic [7:0]        pixel_t;
    typedef logic signed [8:0] dog_t;

    localparam int IMG_W_DEF      = 400;
    localparam int IMG_H_DEF      = 300;
    localparam int BORDER_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 1024;

    localparam dog_t DOG_MIN = -9'sd128;
    localparam dog_t DOG_MAX = 9'sd127;

    // Zero-extended 9-bit subtraction; the result always fits in -255..255.
    function automatic dog_t dog_diff(input pixel_t a, input pixel_t b);
        return dog_t'({1'b0, a} - {1'b0, b});
    endfunction

    function automatic dog_t dog_clamp(input dog_t d);
        if (d < DOG_MIN) return DOG_MIN;
        if (d > DOG_MAX) return DOG_MAX;
        return d;
    endfunction

endpackage

// File: rtl/dog_align_fifo.sv
// Single-clock circular FIFO with occupancy counter; storage has no reset so it maps to RAM.
module dog_align_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (level == LW'(DEPTH));
        empty   = (level == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (en && do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (en) begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/dog_subtract.sv
// Aligns the fine (A) and coarse (B) blur streams and emits A-B with raster tags.
// Optional DOG_CLAMP_EN saturates the difference to [-128,127].
module dog_subtract
    import dog_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int BORDER     = BORDER_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          a_valid,
    input  logic [7:0]                    a_pix,
    input  logic                          b_valid,
    input  logic [7:0]                    b_pix,
    output logic                          dog_valid,
    output logic [8:0]                    dog,
    output logic [$clog2(IMG_W)-1:0]      dog_col,
    output logic [$clog2(IMG_H)-1:0]      dog_row,
    output logic                          dog_border,
    output logic                          dog_eof,
    output logic                          err_ovf,
    output logic                          err_unf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - BORDER);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
    localparam logic [RW-1:0] ROW_HI   = RW'(IMG_H - BORDER);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic          push;
    logic          pop;
    logic          bypass;
    logic          pair;
    logic          fifo_full;
    logic          fifo_empty;
    pixel_t        fifo_rdata;
    pixel_t        a_sel;
    dog_t          dog_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          border;
    logic          last;

    dog_align_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (clk_en),
        .push  (push),
        .pop   (pop),
        .wdata (a_pix),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // With an empty FIFO a simultaneous A pairs straight through instead of being stored.
    always_comb begin
        pop    = b_valid & ~fifo_empty;
        bypass = b_valid & fifo_empty & a_valid;
        pair   = pop | bypass;
        push   = a_valid & ~fifo_full & ~bypass;
        a_sel  = fifo_empty ? a_pix : fifo_rdata;
`ifdef DOG_CLAMP_EN
        dog_next = dog_clamp(dog_diff(a_sel, b_pix));
`else
        dog_next = dog_diff(a_sel, b_pix);
`endif
        border = (row < ROW_LO) || (row >= ROW_HI) || (col < COL_LO) || (col >= COL_HI);
        last   = (row == ROW_LAST) && (col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dog_valid  <= 1'b0;
            dog        <= '0;
            dog_col    <= '0;
            dog_row    <= '0;
            dog_border <= 1'b0;
            dog_eof    <= 1'b0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else if (clk_en) begin
            dog_valid <= pair;
            dog_eof   <= pair & last;
            if (pair) begin
                dog        <= dog_next;
                dog_col    <= col;
                dog_row    <= row;
                dog_border <= border;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (a_valid && fifo_full)                 err_ovf <= 1'b1;
            if (b_valid && fifo_empty && !a_valid)    err_unf <= 1'b1;
        end
    end

endmodule

// File: doc/dog_subtract.md
Name: dog_subtract

Overview:
Difference-of-Gaussians stage, directly downstream of the separable Gaussian blur stages.
- Consumes two 8-bit blurred pixel streams of the same frame: A (finer sigma) and B (coarser sigma, produced later because it is cascaded through one more blur).
- Holds A pixels in an alignment FIFO until the matching B pixel arrives, then emits the signed difference A−B tagged with raster coordinates and a border flag.
- Output feeds the extrema/keypoint detector.

Parameters:
IMG_W, 400, pixels per row (matches the blur line-buffer length)
IMG_H, 300, rows per frame
FIFO_DEPTH, 1024, alignment FIFO entries; must exceed the maximum A-to-B lag (nominally 2*IMG_W+2)
BORDER, 4, rows/cols at each frame edge whose DoG value is flagged invalid

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
clk_en  in  1  global pixel-clock enable; when low all state holds
a_valid  in  1  a_pix valid this cycle
a_pix  in  8  finer-blur pixel, unsigned
b_valid  in  1  b_pix valid this cycle
b_pix  in  8  coarser-blur pixel, unsigned
dog_valid  out  1  dog outputs valid
dog  out  9  signed two's-complement A−B
dog_col  out  $clog2(IMG_W)  column of the current dog pixel
dog_row  out  $clog2(IMG_H)  row of the current dog pixel
dog_border  out  1  pixel lies in the BORDER band
dog_eof  out  1  pulse with the last pixel of the frame
err_ovf  out  1  sticky: A arrived while the FIFO was full
err_unf  out  1  sticky: B arrived with no A available
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous, active-high on rst, clock clk. Reset overrides clk_en.
- Reset values: all outputs 0, FIFO empty, counters 0, sticky errors cleared. Reset mid-frame discards buffered pixels; the next accepted pair is (row 0, col 0).
- All registers update only when clk_en=1. Inputs are sampled only when clk_en=1.
- Push: a_valid=1 and FIFO not full → a_pix is written.
  - a_valid=1 and FIFO full → pixel dropped, err_ovf set.
- Pop and pair: b_valid=1 and FIFO non-empty → head entry is popped and paired with b_pix.
  - Same-cycle push and pop with a non-empty FIFO: both occur, level unchanged.
  - b_valid=1, FIFO empty, a_valid=1 in the same cycle: bypass; a_pix pairs directly with b_pix and nothing is written.
  - b_valid=1, FIFO empty, a_valid=0: B is dropped, err_unf set, no output.
- Arithmetic: dog = {1'b0,A} − {1'b0,B}, 9-bit signed, range −255..255, no overflow.
- Latency: one registered output stage. dog_valid is high in the cycle after a pairing. With clk_en=1, dog_valid is a one-cycle pulse per pair.
- Coordinates are the raster position of the pair being emitted.
  - col increments on each pair and wraps IMG_W−1→0, advancing row.
  - row wraps IMG_H−1→0.
  - dog_eof=1 with the pair at (IMG_H−1, IMG_W−1).
- dog_border = row<BORDER or row≥IMG_H−BORDER or col<BORDER or col≥IMG_W−BORDER. Computed from the same coordinates as the output.
- FIFO is a single-clock circular buffer: read and write pointers wrap at FIFO_DEPTH, full/empty come from an occupancy counter, memory is inferable as RAM.
- Sticky errors clear only on rst.

Optional Feature:
Macro DOG_CLAMP_EN.
- Defined: dog is saturated to [−128,127] before registering (port stays 9 bits, sign-extended), so the downstream detector may use the low 8 bits.
- Undefined: full −255..255 range is passed.

Decomposition:
- Shared package dog_pkg:
  - pixel_t (8-bit unsigned), dog_t (9-bit signed)
  - IMG_W/IMG_H defaults, BORDER default
  - clamp limits DOG_MIN=−128, DOG_MAX=127
- One natural sub-module: dog_align_fifo (parameterised depth/width single-clock FIFO with level, full, empty).
- Subtraction, counters and border logic stay in the top module.

Test Plan:
- Lag test: A stream of 0..255 ramp values; B identical but delayed 802 cycles → dog=0 for every pixel, fifo_level peaks at 802, no errors.
- Difference test: A=200, B=50 → dog=150. A=10, B=250 → dog=−240 (9'h110). With DOG_CLAMP_EN the second case gives −128.
- Bypass: A and B valid together from reset with lag 0 → dog_valid one cycle later, fifo_level stays 0.
- Raster: feed one full 400×300 frame → dog_eof exactly once, at (299, 399).
  - dog_border=1 at (0,0), (3,200), (150,396).
  - dog_border=0 at (4,4), (295,395).
- Errors: B valid before any A → err_unf=1, no dog_valid. Fill FIFO_DEPTH, then one more A → err_ovf=1, level stays 1024.
- Control: clk_en=0 for 10 cycles mid-frame → outputs and level frozen. rst mid-frame → outputs 0, errors cleared, next pair reported at (0,0).
